// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-port arbiter in front of the shared 32x8 program/data memory.
// Port 0 is the CPU control sequencer and port 1 is the loader/debug port.
// The winner's direction, address and write data are latched when it is granted.
// The memory strobes are then held for ACC_CYC cycles, followed by a one-cycle ack.
// Optional feature macro ARB_ROUND_ROBIN_EN: alternate between the ports on ties.
// Without it, port 0 wins every tie.
module mem_bus_arbiter #(
  parameter int AW      = 5,
  parameter int DW      = 8,
  parameter int ACC_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          gnt0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          gnt1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ACC_CYC - 1);

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          we_lat, we_lat_nxt;
  logic          win, win_nxt;
  logic          pick;
  logic          ack0_nxt, ack1_nxt, gnt0_nxt, gnt1_nxt;
  logic          mem_rd_nxt, mem_wr_nxt;
  logic [DW-1:0] rdata_nxt, mem_wdata_nxt;
  logic [AW-1:0] mem_addr_nxt;
`ifdef ARB_ROUND_ROBIN_EN
  logic          last_served, last_served_nxt;
`endif

  // Choose which port would win if the arbiter grants this cycle (0 = CPU, 1 = loader)
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    if (req0 && req1) pick = ~last_served;
    else              pick = ~req0;
`else
    pick = ~req0;
`endif
  end

  // State register and every registered output; reset clears them all at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      we_lat    <= 1'b0;
      win       <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_served <= 1'b1;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      we_lat    <= we_lat_nxt;
      win       <= win_nxt;
      ack0      <= ack0_nxt;
      ack1      <= ack1_nxt;
      gnt0      <= gnt0_nxt;
      gnt1      <= gnt1_nxt;
      mem_rd    <= mem_rd_nxt;
      mem_wr    <= mem_wr_nxt;
      rdata     <= rdata_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      last_served <= last_served_nxt;
`endif
    end
  end

  // Next-state logic: grant in IDLE, hold the strobes through ACCESS, pulse ack in DONE
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    we_lat_nxt    = we_lat;
    win_nxt       = win;
    ack0_nxt      = 1'b0;
    ack1_nxt      = 1'b0;
    gnt0_nxt      = gnt0;
    gnt1_nxt      = gnt1;
    mem_rd_nxt    = 1'b0;
    mem_wr_nxt    = 1'b0;
    rdata_nxt     = rdata;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
`ifdef ARB_ROUND_ROBIN_EN
    last_served_nxt = last_served;
`endif
    case (state)
      IDLE: begin
        gnt0_nxt = 1'b0;
        gnt1_nxt = 1'b0;
        if (req0 || req1) begin
          win_nxt       = pick;
          we_lat_nxt    = pick ? we1 : we0;
          mem_addr_nxt  = pick ? addr1 : addr0;
          mem_wdata_nxt = pick ? wdata1 : wdata0;
          gnt0_nxt      = ~pick;
          gnt1_nxt      = pick;
          cnt_nxt       = CNT_INIT;
          mem_rd_nxt    = pick ? ~we1 : ~we0;
          mem_wr_nxt    = pick ? we1 : we0;
          state_nxt     = ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
          last_served_nxt = pick;
`endif
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_nxt = DONE;
          ack0_nxt  = ~win;
          ack1_nxt  = win;
          if (!we_lat) rdata_nxt = mem_rdata;
        end else begin
          cnt_nxt    = cnt - 4'd1;
          mem_rd_nxt = ~we_lat;
          mem_wr_nxt = we_lat;
        end
      end
      DONE: begin
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule
